// File: rtl/instr_encoder_loader_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_if
// Purpose : valid/ready descriptor stream carrying one mnemonic-level
//           instruction descriptor per transfer into the instruction loader.
// Signals : in_valid  - descriptor valid (master -> slave)
//           in_ready  - slave can accept this cycle (slave -> master)
//           in_op     - opcode 0..8 legal, 9..15 illegal
//           in_ra     - first register field
//           in_rb     - second register field
//           in_imm    - ADDI immediate / BZ target index
//           in_hh     - ADDI destination register / BZ how_high
//           in_last   - final descriptor of the program
// Modports: master (descriptor source), slave (loader)
// -----------------------------------------------------------------------------
interface instr_encoder_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [2:0] in_ra;
   logic [2:0] in_rb;
   logic [2:0] in_imm;
   logic [1:0] in_hh;
   logic       in_last;

   modport master (
      output in_valid, in_op, in_ra, in_rb, in_imm, in_hh, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_ra, in_rb, in_imm, in_hh, in_last,
      output in_ready
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Purpose : packs instruction descriptors into 9-bit machine words and writes
//           them sequentially into instruction memory starting at address 0.
//           An IDLE/LOAD/DONE/ERROR FSM tracks the load, with a word counter
//           and a sticky error code.
// Ports   : clk        - clock, rising edge
//           reset      - asynchronous active-high reset
//           start      - pulse: (re)start a load at address 0
//           in_if      - descriptor stream (slave modport)
//           imem_we    - one-cycle write strobe per encoded word
//           imem_addr  - write address
//           imem_wdata - encoded machine word
//           busy/done/err - FSM in LOAD / DONE / ERROR
//           err_code   - 00 none, 01 illegal op, 10 overflow
//           word_count - words written in the current load
//           checksum   - running XOR of written words (only with
//                        LOADER_CHECKSUM_EN defined)
// Config  : LOADER_CHECKSUM_EN adds the checksum output and its register.
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int MW    = 9,
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   instr_encoder_loader_if.slave  in_if,
   output logic                   imem_we,
   output logic [AW-1:0]          imem_addr,
   output logic [MW-1:0]          imem_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [AW:0]            word_count
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [MW-1:0]          checksum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [AW:0]       word_count_q, word_count_d;
   logic              imem_we_q, imem_we_d;
   logic [AW-1:0]     imem_addr_q, imem_addr_d;
   logic [MW-1:0]     imem_wdata_q, imem_wdata_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              accept_s;
   logic              illegal_s;
   logic              write_s;
   logic              overflow_s;
   logic              ready_s;
   logic [MW-1:0]     code_s;
`ifdef LOADER_CHECKSUM_EN
   logic [MW-1:0]     checksum_q, checksum_d;
`endif

   // Pack one descriptor into machine code; ops 7/8 share the 3'b111 prefix
   // and are told apart by bit 5.
   function automatic logic [MW-1:0] encode(
      input logic [3:0] op,
      input logic [2:0] ra,
      input logic [2:0] rb,
      input logic [2:0] imm,
      input logic [1:0] hh
   );
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3,
         4'd4, 4'd5, 4'd6: encode = {op[2:0], ra, rb};
         4'd7:             encode = {3'b111, 1'b1, hh, imm};
         4'd8:             encode = {3'b111, 1'b0, hh, imm};
         default:          encode = {MW{1'b0}};
      endcase
   endfunction

   // Handshake qualification; start wins over a same-cycle handshake.
   always_comb begin
      ready_s    = (state_q == S_LOAD) && (word_count_q < DEPTH_C);
      illegal_s  = (in_if.in_op > 4'd8);
      accept_s   = in_if.in_valid && ready_s && !start;
      write_s    = accept_s && !illegal_s;
      // Full with no in_last seen: the cycle after the DEPTH-th accept.
      overflow_s = (state_q == S_LOAD) && (word_count_q == DEPTH_C);
      code_s     = encode(in_if.in_op, in_if.in_ra, in_if.in_rb,
                          in_if.in_imm, in_if.in_hh);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_LOAD;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (accept_s && illegal_s) begin
                  state_d = S_ERROR;
               end else if (accept_s && in_if.in_last) begin
                  state_d = S_DONE;
               end else if (overflow_s) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_LOAD;
               end
            end
            S_IDLE:  state_d = S_IDLE;
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM output decode.
   always_comb begin
      busy           = 1'b0;
      done           = 1'b0;
      err            = 1'b0;
      in_if.in_ready = ready_s;
      case (state_q)
         S_LOAD:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         S_ERROR: err  = 1'b1;
         S_IDLE:  busy = 1'b0;
         default: busy = 1'b0;
      endcase
   end

   // Datapath next values: write port, word counter, sticky error code.
   always_comb begin
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      word_count_d = word_count_q;
      err_code_d   = err_code_q;
`ifdef LOADER_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      if (start) begin
         imem_addr_d  = {AW{1'b0}};
         word_count_d = {(AW+1){1'b0}};
         err_code_d   = 2'b00;
`ifdef LOADER_CHECKSUM_EN
         checksum_d   = {MW{1'b0}};
`endif
      end else begin
         if (write_s) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[AW-1:0];
            imem_wdata_d = code_s;
            word_count_d = word_count_q + {{AW{1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
            checksum_d   = checksum_q ^ code_s;
`endif
         end else begin
            imem_we_d    = 1'b0;
         end
         if (accept_s && illegal_s) begin
            err_code_d = 2'b01;
         end else if (overflow_s) begin
            err_code_d = 2'b10;
         end else begin
            err_code_d = err_code_q;
         end
      end
   end

   // Datapath registers; async reset also squashes a pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we_q    <= 1'b0;
         imem_addr_q  <= {AW{1'b0}};
         imem_wdata_q <= {MW{1'b0}};
         word_count_q <= {(AW+1){1'b0}};
         err_code_q   <= 2'b00;
`ifdef LOADER_CHECKSUM_EN
         checksum_q   <= {MW{1'b0}};
`endif
      end else begin
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         word_count_q <= word_count_d;
         err_code_q   <= err_code_d;
`ifdef LOADER_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign word_count = word_count_q;
   assign err_code   = err_code_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed descriptors with hand-computed machine words. Each accepted legal
// descriptor pushes its expected {addr, wdata} into a queue; an independent
// monitor pops and compares on every imem_we. Status outputs are checked
// directly by the stimulus process. DUT is built with DEPTH=4 so the
// overflow boundary is reachable.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;
   localparam int MW    = 9;
   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           imem_we;
   logic [AW-1:0]  imem_addr;
   logic [MW-1:0]  imem_wdata;
   logic           busy, done, err;
   logic [1:0]     err_code;
   logic [AW:0]    word_count;
`ifdef LOADER_CHECKSUM_EN
   logic [MW-1:0]  checksum;
`endif

   instr_encoder_loader_if bus();

   instr_encoder_loader #(.MW(MW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_if      (bus),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [AW+MW-1:0] exp_q[$];
   logic [AW-1:0]    exp_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   logic [AW+MW-1:0] mon_e;
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %03h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("write_addr", 32'(imem_addr), 32'(mon_e[AW+MW-1:MW]));
            chk("write_data", 32'(imem_wdata), 32'(mon_e[MW-1:0]));
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] imm, input logic [1:0] hh, input logic last,
                        input logic exp_rdy, input logic [MW-1:0] word);
      @(negedge clk);
      bus.in_op    = op;
      bus.in_ra    = ra;
      bus.in_rb    = rb;
      bus.in_imm   = imm;
      bus.in_hh    = hh;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (exp_rdy && (op <= 4'd8)) begin
         exp_q.push_back({exp_addr, word});
         exp_addr = exp_addr + 8'd1;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_addr = '0;
   endtask

   task automatic chk_status(input logic b, input logic d, input logic e,
                             input logic [1:0] ec, input logic [AW:0] wc);
      @(negedge clk);
      chk("busy", 32'(busy), 32'(b));
      chk("done", 32'(done), 32'(d));
      chk("err", 32'(err), 32'(e));
      chk("err_code", 32'(err_code), 32'(ec));
      chk("word_count", 32'(word_count), 32'(wc));
   endtask

   task automatic chk_all_zero();
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_op    = 4'd0;
      bus.in_ra    = 3'd0;
      bus.in_rb    = 3'd0;
      bus.in_imm   = 3'd0;
      bus.in_hh    = 3'd0;
      bus.in_last  = 1'b0;
      #12;
      chk_all_zero();
      @(negedge clk);
      reset = 1'b0;

      // Single ADD with last.
      do_start();
      chk_status(1'b1, 1'b0, 1'b0, 2'b00, 9'd0);
      issue(4'd0, 3'd2, 3'd5, 3'd0, 2'd0, 1'b1, 1'b1, 9'b000_010_101);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd1);
      chk("in_ready_done", 32'(bus.in_ready), 32'd0);

      // ADDI then BZ; register fields must be ignored.
      do_start();
      issue(4'd7, 3'd5, 3'd6, 3'd4, 2'd3, 1'b0, 1'b1, 9'b111_1_11_100);
      issue(4'd8, 3'd1, 3'd1, 3'd1, 2'd2, 1'b1, 1'b1, 9'b111_0_10_001);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd2);

      // NAND, idle gap, SUB, LSR; imm/hh fields must be ignored.
      do_start();
      issue(4'd3, 3'd7, 3'd0, 3'd5, 2'd1, 1'b0, 1'b1, 9'b011_111_000);
      @(negedge clk);
      issue(4'd4, 3'd1, 3'd3, 3'd7, 2'd3, 1'b0, 1'b1, 9'b100_001_011);
      issue(4'd2, 3'd4, 3'd4, 3'd7, 2'd3, 1'b1, 1'b1, 9'b010_100_100);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd3);

      // Words 0x0A5 and 0x1FF (checksum 0x15A when enabled).
      do_start();
      issue(4'd2, 3'd4, 3'd5, 3'd0, 2'd0, 1'b0, 1'b1, 9'h0A5);
      issue(4'd7, 3'd0, 3'd0, 3'd7, 2'd3, 1'b1, 1'b1, 9'h1FF);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd2);
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'h15A);
`endif

      // Illegal op: no write, ERROR, then restart clears the code.
      do_start();
      issue(4'd12, 3'd1, 3'd2, 3'd3, 2'd1, 1'b0, 1'b1, 9'd0);
      chk_status(1'b0, 1'b0, 1'b1, 2'b01, 9'd0);
      chk("in_ready_error", 32'(bus.in_ready), 32'd0);
      issue(4'd0, 3'd1, 3'd1, 3'd0, 2'd0, 1'b0, 1'b0, 9'd0);
      do_start();
      chk_status(1'b1, 1'b0, 1'b0, 2'b00, 9'd0);
      issue(4'd1, 3'd6, 3'd2, 3'd0, 2'd0, 1'b1, 1'b1, 9'b001_110_010);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd1);

      // Overflow: DEPTH non-last words, next one refused.
      do_start();
      issue(4'd6, 3'd3, 3'd7, 3'd0, 2'd0, 1'b0, 1'b1, 9'b110_011_111);
      issue(4'd5, 3'd0, 3'd1, 3'd0, 2'd0, 1'b0, 1'b1, 9'b101_000_001);
      issue(4'd0, 3'd1, 3'd1, 3'd0, 2'd0, 1'b0, 1'b1, 9'b000_001_001);
      issue(4'd4, 3'd7, 3'd7, 3'd0, 2'd0, 1'b0, 1'b1, 9'b100_111_111);
      issue(4'd0, 3'd2, 3'd2, 3'd0, 2'd0, 1'b0, 1'b0, 9'd0);
      chk_status(1'b0, 1'b0, 1'b1, 2'b10, 9'd4);

      // DEPTH-th word carries last: DONE, no error.
      do_start();
      issue(4'd0, 3'd1, 3'd2, 3'd0, 2'd0, 1'b0, 1'b1, 9'b000_001_010);
      issue(4'd1, 3'd3, 3'd4, 3'd0, 2'd0, 1'b0, 1'b1, 9'b001_011_100);
      issue(4'd2, 3'd5, 3'd6, 3'd0, 2'd0, 1'b0, 1'b1, 9'b010_101_110);
      issue(4'd3, 3'd7, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 9'b011_111_000);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd4);

      // Reset right after an accept squashes the pending write.
      do_start();
      @(negedge clk);
      bus.in_op    = 4'd0;
      bus.in_ra    = 3'd3;
      bus.in_rb    = 3'd3;
      bus.in_last  = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk_all_zero();
      @(negedge clk);
      chk("rst_hold_we", 32'(imem_we), 32'd0);
      reset = 1'b0;

      // Fresh load after reset starts again at address 0.
      do_start();
      issue(4'd0, 3'd2, 3'd5, 3'd0, 2'd0, 1'b1, 1'b1, 9'b000_010_101);
      chk_status(1'b0, 1'b1, 1'b0, 2'b00, 9'd1);

      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
